fir_to_posit_pipe: RTL and testbench

- Pipelined posit encoder that sits downstream of the arithmetic core.
- Accepts the core's intermediate result (sign, total exponent, full fraction, truncation flag, special-value flags) and emits a rounded N-bit posit.
- Two register stages with valid/ready handshake on both sides, so the core output can be registered and back-pressured by the writeback path.

---
 rtl/fir_to_posit_pipe.sv | 149 ++++++++++++++
 tb/tb_fir_to_posit_pipe.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fir_to_posit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fir_to_posit_pipe
// Brief    : Two-stage valid/ready posit encoder: regime/field assembly, then
//            round-to-nearest-even with saturation, sign and special values.
// Revision : 1.0 - initial release
// ============================================================================
module fir_to_posit_pipe #(
    parameter int N              = 16,
    parameter int ES             = 1,
    parameter int TE_BITS        = 7,
    parameter int FRAC_FULL_SIZE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [TE_BITS-1:0]        in_te,
    input  logic [FRAC_FULL_SIZE-1:0] in_frac,
    input  logic                      in_frac_truncated,
    input  logic                      in_is_zero,
    input  logic                      in_is_nar,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0]              out_posit
);

    // Assembled string: longest legal regime (N-1 bits) followed by e and fraction.
    localparam int                         c_sw    = N - 1 + ES + FRAC_FULL_SIZE;
    localparam logic signed [TE_BITS-1:0]  c_k_max = TE_BITS'(N - 2);
    localparam logic signed [TE_BITS-1:0]  c_k_min = TE_BITS'(-(N - 1));
    localparam logic [N-2:0]               c_maxpos = {(N-1){1'b1}};
    localparam logic [N-2:0]               c_minpos = {{(N-2){1'b0}}, 1'b1};

    // ---------------- stage 1 combinational ----------------
    logic signed [TE_BITS-1:0] w_k;
    logic                      w_k_neg;
    logic [TE_BITS-1:0]        w_kmag;
    logic [TE_BITS-1:0]        w_rlen;
    logic [c_sw-1:0]           w_regime;
    logic [c_sw-1:0]           w_tail;
    logic [c_sw-1:0]           w_str;
    logic                      w_sat_max;
    logic                      w_sat_min;
    logic                      w_s1_advance;

    always_comb begin
        w_k     = $signed(in_te) >>> ES;
        w_k_neg = w_k[TE_BITS-1];
        w_kmag  = w_k_neg ? TE_BITS'(-w_k) : TE_BITS'(w_k);
        if (!w_k_neg) begin
            w_regime = ~({c_sw{1'b1}} >> (w_kmag + 1));
            w_rlen   = w_kmag + TE_BITS'(2);
        end else begin
            w_regime = {1'b1, {(c_sw-1){1'b0}}} >> w_kmag;
            w_rlen   = w_kmag + TE_BITS'(1);
        end
        w_tail    = {in_te[ES-1:0], in_frac, {(N-1){1'b0}}} >> w_rlen;
        w_str     = w_regime | w_tail;
        w_sat_max = !w_k_neg && (w_k >= c_k_max);
        w_sat_min = w_k <= c_k_min;
    end

    // ---------------- stage 1 registers ----------------
    logic          r_s1_valid;
    logic [N-2:0]  r_s1_body;
    logic          r_s1_guard;
    logic          r_s1_sticky;
    logic          r_s1_sign;
    logic          r_s1_sat_max;
    logic          r_s1_sat_min;
    logic          r_s1_zero;
    logic          r_s1_nar;
    logic          r_s2_valid;
    logic [N-1:0]  r_s2_posit;

    assign w_s1_advance = !r_s2_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_body    <= '0;
            r_s1_guard   <= 1'b0;
            r_s1_sticky  <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_sat_max <= 1'b0;
            r_s1_sat_min <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_nar     <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_body    <= w_str[c_sw-1 -: N-1];
                r_s1_guard   <= w_str[c_sw-N];
                r_s1_sticky  <= (|w_str[c_sw-N-1:0]) | in_frac_truncated;
                r_s1_sign    <= in_sign;
                r_s1_sat_max <= w_sat_max;
                r_s1_sat_min <= w_sat_min;
                r_s1_zero    <= in_is_zero;
                r_s1_nar     <= in_is_nar;
            end
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic          w_round_up;
    logic [N-1:0]  w_sum;
    logic [N-2:0]  w_mag;
    logic [N-1:0]  w_posit;

    always_comb begin
        w_round_up = r_s1_guard & (r_s1_sticky | r_s1_body[0]);
        w_sum      = {1'b0, r_s1_body} + {{(N-1){1'b0}}, w_round_up};
        // A carry into the sign position would wrap past maxpos, so clamp it.
        if (r_s1_sat_max || w_sum[N-1]) begin
            w_mag = c_maxpos;
        end else if (r_s1_sat_min || (w_sum[N-2:0] == '0)) begin
            w_mag = c_minpos;
        end else begin
            w_mag = w_sum[N-2:0];
        end
        w_posit = r_s1_sign ? -{1'b0, w_mag} : {1'b0, w_mag};
        if (r_s1_nar) begin
            w_posit = {1'b1, {(N-1){1'b0}}};
        end else if (r_s1_zero) begin
            w_posit = '0;
        end
    end

    // ---------------- stage 2 registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_posit <= '0;
        end else if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_posit <= w_posit;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_posit = r_s2_posit;

endmodule
`default_nettype wire

// File: tb/tb_fir_to_posit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_to_posit_pipe
// Brief    : Directed self-checking bench for fir_to_posit_pipe (N=16, ES=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_to_posit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [6:0]  in_te;
    logic [31:0] in_frac;
    logic        in_frac_truncated;
    logic        in_is_zero;
    logic        in_is_nar;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_posit;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fir_to_posit_pipe #(
        .N              (16),
        .ES             (1),
        .TE_BITS        (7),
        .FRAC_FULL_SIZE (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_sign           (in_sign),
        .in_te             (in_te),
        .in_frac           (in_frac),
        .in_frac_truncated (in_frac_truncated),
        .in_is_zero        (in_is_zero),
        .in_is_nar         (in_is_nar),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_posit         (out_posit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sign, input int te, input logic [31:0] frac,
                         input logic trunc, input logic zero, input logic nar);
        in_sign           = sign;
        in_te             = 7'(te);
        in_frac           = frac;
        in_frac_truncated = trunc;
        in_is_zero        = zero;
        in_is_nar         = nar;
    endtask

    // One isolated beat: accept, empty after one edge, valid with the result after two.
    task automatic run_vec(input string tag, input logic sign, input int te,
                           input logic [31:0] frac, input logic trunc,
                           input logic zero, input logic nar, input logic [15:0] exp);
        drive(sign, te, frac, trunc, zero, nar);
        in_valid = 1'b1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_val"}, 32'(out_posit), 32'(exp));
        @(posedge clk); #1;
    endtask

    logic [15:0] bp_exp [5];
    int          bp_te  [5];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_posit", 32'(out_posit), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        run_vec("te0",      0,   0, 32'h0,        0, 0, 0, 16'h4000);
        run_vec("te1",      0,   1, 32'h0,        0, 0, 0, 16'h5000);
        run_vec("tem1",     0,  -1, 32'h0,        0, 0, 0, 16'h3000);
        run_vec("neg_te0",  1,   0, 32'h0,        0, 0, 0, 16'hC000);
        run_vec("frac_1p5", 0,   0, 32'h8000_0000,0, 0, 0, 16'h4800);
        // Body holds frac[31:20] at te=0, so frac[19] is the guard bit.
        run_vec("rne_tie",  0,   0, 32'h0008_0000,0, 0, 0, 16'h4000);
        run_vec("rne_stky", 0,   0, 32'h0008_0000,1, 0, 0, 16'h4001);
        run_vec("rne_odd",  0,   0, 32'h0018_0000,0, 0, 0, 16'h4002);
        run_vec("k13",      0,  26, 32'h0,        0, 0, 0, 16'h7FFE);
        run_vec("k13_up",   0,  27, 32'h1,        0, 0, 0, 16'h7FFF);
        run_vec("k14_sat",  0,  28, 32'h0,        0, 0, 0, 16'h7FFF);
        run_vec("km14_up",  0, -27, 32'h0,        0, 0, 0, 16'h0002);
        run_vec("sat_max",  0,  40, 32'h0,        0, 0, 0, 16'h7FFF);
        run_vec("sat_maxn", 1,  40, 32'h0,        0, 0, 0, 16'h8001);
        run_vec("sat_min",  0, -40, 32'h0,        0, 0, 0, 16'h0001);
        run_vec("zero",     1,   5, 32'hFFFF_0000,1, 1, 0, 16'h0000);
        run_vec("nar",      0,   3, 32'h0,        0, 1, 1, 16'h8000);

        // Back-pressure: five beats, consumer stalls in cycles 3..6.
        bp_te  = '{0, 1, -1, 2, -2};
        bp_exp = '{16'h4000, 16'h5000, 16'h3000, 16'h6000, 16'h2000};
        begin
            int sent = 0;
            int recv = 0;
            for (int c = 0; c < 14; c++) begin
                out_ready = !(c >= 3 && c <= 6);
                in_valid  = (sent < 5);
                if (sent < 5) drive(1'b0, bp_te[sent], 32'h0, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                if (c >= 3 && c <= 6) check("bp_in_ready_low", 32'(in_ready), 32'd0);
                if (out_valid) begin
                    if (recv < 5) begin
                        check($sformatf("bp_beat%0d", recv), 32'(out_posit), 32'(bp_exp[recv]));
                        if (out_ready) recv++;
                    end else begin
                        check("bp_extra", 32'(out_valid), 32'd0);
                    end
                end
                if (in_valid && in_ready) sent++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            check("bp_sent", 32'(sent), 32'd5);
            check("bp_recv", 32'(recv), 32'd5);
        end

        // Reset with both stages occupied.
        out_ready = 1'b1;
        drive(1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_ready", 32'(in_ready),  32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
